// File: rtl/i2c_slave_phy_fsm.sv
// -----------------------------------------------------------------------------
// i2c_slave_phy_fsm
// I2C slave bus engine for the backplane CPLD. Conditions the raw SCL/SDA pins
// (2-FF synchronizer plus glitch filter), detects START / repeated START / STOP,
// shifts address, command and data bytes in, ACKs on address match and shifts
// read bytes out. The phase encoding, received byte, address and direction feed
// the BMC memory-map block, which returns the read byte on rd_lock_data.
//
// Ports
//   cpld_internal_clk  system clock, rising edge
//   rst_sync_clk       synchronous active-high reset
//   scl_in, sda_in     raw bus pins
//   sda_oe             1 = pull SDA low, 0 = release
//   correct_address    7-bit slave address to match
//   rd_lock_data       byte to transmit on read
//   addr_in, r_w       address field / R/W bit of the last address byte
//   data_out           last received byte
//   sm_state           current phase (IDLE=0 TIP=1 ADDR=2 DATA=3 CMD=4 ACK=5)
//   pre_sm_state       last completed byte phase
//   bus_busy           START seen, no STOP/abort yet
//   timeout_err        one-cycle pulse on SCL-low timeout abort
// -----------------------------------------------------------------------------
module i2c_slave_phy_fsm #(
  parameter int          FILTER_LEN     = 3,
  parameter logic [19:0] TIMEOUT_CYCLES = 20'd500000
) (
  input  logic       cpld_internal_clk,
  input  logic       rst_sync_clk,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  input  logic [6:0] correct_address,
  input  logic [7:0] rd_lock_data,
  output logic [6:0] addr_in,
  output logic [7:0] data_out,
  output logic       r_w,
  output logic [2:0] sm_state,
  output logic [2:0] pre_sm_state,
  output logic       bus_busy,
  output logic       timeout_err
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_TIP  = 3'd1,
    ST_ADDR = 3'd2,
    ST_DATA = 3'd3,
    ST_CMD  = 3'd4,
    ST_ACK  = 3'd5
  } state_t;

  // ---------------------------------------------------------------------------
  // Input conditioning
  // ---------------------------------------------------------------------------
  logic [1:0]            scl_sync_q, sda_sync_q;
  logic [FILTER_LEN-2:0] scl_hist_q, sda_hist_q;
  logic                  scl_filt_q, sda_filt_q;
  logic                  scl_prev_q, sda_prev_q;
  logic [FILTER_LEN-1:0] scl_win, sda_win;

  // Window = current synchronized sample plus the previous FILTER_LEN-1, so
  // the filtered level moves 2+FILTER_LEN cycles after the pin.
  assign scl_win = {scl_hist_q, scl_sync_q[1]};
  assign sda_win = {sda_hist_q, sda_sync_q[1]};

  always_ff @(posedge cpld_internal_clk) begin
    if (rst_sync_clk) begin
      // Everything presets high: an idle bus must not look like a START.
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
      scl_hist_q <= '1;
      sda_hist_q <= '1;
      scl_filt_q <= 1'b1;
      sda_filt_q <= 1'b1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments model the flops in parallel; blocking
      // here would collapse the synchronizer chain into a single stage.
      scl_sync_q <= {scl_sync_q[0], scl_in};
      sda_sync_q <= {sda_sync_q[0], sda_in};
      scl_hist_q <= scl_win[FILTER_LEN-2:0];
      sda_hist_q <= sda_win[FILTER_LEN-2:0];
      if (&scl_win)       scl_filt_q <= 1'b1;
      else if (~|scl_win) scl_filt_q <= 1'b0;
      if (&sda_win)       sda_filt_q <= 1'b1;
      else if (~|sda_win) sda_filt_q <= 1'b0;
      scl_prev_q <= scl_filt_q;
      sda_prev_q <= sda_filt_q;
    end
  end

  logic scl_rise, scl_fall, start_det, stop_det;
  assign scl_rise  =  scl_filt_q & ~scl_prev_q;
  assign scl_fall  = ~scl_filt_q &  scl_prev_q;
  assign start_det =  scl_filt_q &  sda_prev_q & ~sda_filt_q;
  assign stop_det  =  scl_filt_q & ~sda_prev_q &  sda_filt_q;

  // ---------------------------------------------------------------------------
  // Protocol FSM
  // ---------------------------------------------------------------------------
  state_t      state_q, state_d, pre_q, pre_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  rx_q, rx_d, tx_q, tx_d, data_q, data_d;
  logic [6:0]  addr_q, addr_d;
  logic        r_w_q, r_w_d, oe_q, oe_d, busy_q, busy_d;
  logic        to_err_q, to_err_d, nack_q, nack_d;
  logic [19:0] to_cnt_q, to_cnt_d;
  logic [7:0]  rx_byte;
  logic        to_hit;

  assign rx_byte = {rx_q[6:0], sda_filt_q};
  assign to_hit  = busy_q && !scl_filt_q && (to_cnt_q == TIMEOUT_CYCLES - 20'd1);

  always_comb begin
    // NOTE: every _d gets a hold default first so no path through the
    // case below leaves a variable unassigned and infers a latch.
    state_d   = state_q;
    pre_d     = pre_q;
    bit_cnt_d = bit_cnt_q;
    rx_d      = rx_q;
    tx_d      = tx_q;
    data_d    = data_q;
    addr_d    = addr_q;
    r_w_d     = r_w_q;
    oe_d      = oe_q;
    busy_d    = busy_q;
    to_err_d  = 1'b0;
    nack_d    = nack_q;
    to_cnt_d  = (busy_q && !scl_filt_q) ? to_cnt_q + 20'd1 : 20'd0;

    // START outranks STOP and timeout; it may arrive in any phase.
    if (start_det) begin
      state_d   = ST_ADDR;
      pre_d     = ST_IDLE;
      bit_cnt_d = 4'd0;
      busy_d    = 1'b1;
      oe_d      = 1'b0;
      to_cnt_d  = 20'd0;
    end else if (stop_det) begin
      state_d   = ST_IDLE;
      pre_d     = ST_IDLE;
      bit_cnt_d = 4'd0;
      busy_d    = 1'b0;
      oe_d      = 1'b0;
    end else if (to_hit) begin
      state_d   = ST_IDLE;
      bit_cnt_d = 4'd0;
      busy_d    = 1'b0;
      oe_d      = 1'b0;
      to_err_d  = 1'b1;
      to_cnt_d  = 20'd0;
    end else begin
      case (state_q)
        ST_IDLE: oe_d = 1'b0;

        ST_ADDR, ST_CMD, ST_DATA: begin
          if (scl_rise && bit_cnt_q != 4'd8) begin
            rx_d      = rx_byte;
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              data_d = rx_byte;
              if (state_q == ST_ADDR) begin
                addr_d = rx_byte[7:1];
                r_w_d  = rx_byte[0];
              end
            end
          end else if (scl_fall) begin
            if (bit_cnt_q == 4'd8) begin
              state_d   = ST_ACK;
              pre_d     = state_q;
              bit_cnt_d = 4'd0;
              if (state_q == ST_ADDR)               oe_d = (addr_q == correct_address);
              else if (state_q == ST_DATA && r_w_q) oe_d = 1'b0;  // master's ACK slot
              else                                  oe_d = 1'b1;
            end else if (state_q == ST_DATA && r_w_q && bit_cnt_q != 4'd0) begin
              // Transmit: present the next bit while SCL is low.
              tx_d = {tx_q[6:0], 1'b0};
              oe_d = ~tx_q[6];
            end
          end
        end

        ST_ACK: begin
          if (scl_rise) begin
            nack_d = sda_filt_q;
          end else if (scl_fall) begin
            bit_cnt_d = 4'd0;
            if ((pre_q == ST_ADDR && addr_q != correct_address) ||
                (pre_q == ST_DATA && r_w_q && nack_q)) begin
              state_d = ST_IDLE;
              oe_d    = 1'b0;
            end else begin
              state_d = ST_TIP;
              if (r_w_q) begin
                // rd_lock_data is settled by the end of ACK; drive its MSB now.
                tx_d = rd_lock_data;
                oe_d = ~rd_lock_data[7];
              end else begin
                oe_d = 1'b0;
              end
            end
          end
        end

        ST_TIP: begin
          if (r_w_q) begin
            state_d   = ST_DATA;
            bit_cnt_d = 4'd0;
          end else if (scl_rise) begin
            // This rise already carries the MSB of the next byte.
            state_d   = (pre_q == ST_ADDR) ? ST_CMD : ST_DATA;
            rx_d      = rx_byte;
            bit_cnt_d = 4'd1;
          end
        end

        default: begin
          state_d = ST_IDLE;
          oe_d    = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge cpld_internal_clk) begin
    if (rst_sync_clk) begin
      state_q   <= ST_IDLE;
      pre_q     <= ST_IDLE;
      bit_cnt_q <= 4'd0;
      rx_q      <= 8'h00;
      tx_q      <= 8'h00;
      data_q    <= 8'h00;
      addr_q    <= 7'h00;
      r_w_q     <= 1'b0;
      oe_q      <= 1'b0;
      busy_q    <= 1'b0;
      to_err_q  <= 1'b0;
      nack_q    <= 1'b0;
      to_cnt_q  <= 20'd0;
    end else begin
      state_q   <= state_d;
      pre_q     <= pre_d;
      bit_cnt_q <= bit_cnt_d;
      rx_q      <= rx_d;
      tx_q      <= tx_d;
      data_q    <= data_d;
      addr_q    <= addr_d;
      r_w_q     <= r_w_d;
      oe_q      <= oe_d;
      busy_q    <= busy_d;
      to_err_q  <= to_err_d;
      nack_q    <= nack_d;
      to_cnt_q  <= to_cnt_d;
    end
  end

  assign sda_oe       = oe_q;
  assign sm_state     = state_q;
  assign pre_sm_state = pre_q;
  assign addr_in      = addr_q;
  assign data_out     = data_q;
  assign r_w          = r_w_q;
  assign bus_busy     = busy_q;
  assign timeout_err  = to_err_q;

endmodule

// File: doc/i2c_slave_phy_fsm.md
Name: i2c_slave_phy_fsm

Overview:
- I2C slave bus engine for the backplane CPLD. Sits directly upstream of the BMC memory-map block.
- Synchronizes and filters SCL/SDA, and detects START, repeated START and STOP.
- Shifts in address, command and data bytes, ACKs on address match, and shifts out read bytes.
- Publishes the phase encoding (sm_state/pre_sm_state), the received byte, address and direction that the memory map consumes. Takes the memory map's rd_lock_data as the read byte source.

Parameters:
- FILTER_LEN, 3: consecutive identical synchronized samples required before a filtered SCL/SDA level changes (glitch filter).
- TIMEOUT_CYCLES, 20'd500000: SCL-low clock count, while not idle, that aborts the transfer.

Ports:
- cpld_internal_clk  in  1  system clock; all logic on rising edge.
- rst_sync_clk  in  1  reset, synchronous, active-high.
- scl_in  in  1  raw SCL pin.
- sda_in  in  1  raw SDA pin.
- sda_oe  out  1  1 = pull SDA low (open-drain enable); 0 = release.
- correct_address  in  7  slave address to match.
- rd_lock_data  in  8  byte to transmit on read, from the memory map.
- addr_in  out  7  address field of the last address byte.
- data_out  out  8  last received byte (address, command or data).
- r_w  out  1  R/W bit of the last address byte; 1 = read.
- sm_state  out  3  current phase.
- pre_sm_state  out  3  last completed byte phase.
- bus_busy  out  1  high from START until STOP or abort.
- timeout_err  out  1  one-cycle pulse on timeout abort.

Behaviour:
- Phase encoding:
  - IDLE=0, TIP=1, ADDR=2, DATA=3, CMD=4, ACK=5.
  - 6 and 7 are never driven.
- Input conditioning:
  - 2-FF synchronizer, then FILTER_LEN filter.
  - Latency from pin to filtered level is 2+FILTER_LEN cycles.
  - Edges are detected on filtered levels.
- START (filtered SDA fall while SCL high), valid in any state including mid-byte:
  - Clears the bit counter and sets bus_busy=1.
  - Enters ADDR; pre_sm_state=IDLE; sda_oe=0.
- STOP (SDA rise while SCL high):
  - Enters IDLE; pre_sm_state=IDLE; bus_busy=0; sda_oe=0.
- Byte phases (ADDR/CMD/DATA):
  - Received bits are sampled MSB-first on SCL rise.
  - After the 8th rise, data_out is updated with the byte. On the following SCL fall the block enters ACK and pre_sm_state takes the byte phase just completed.
  - After an ADDR byte, addr_in=byte[7:1] and r_w=byte[0]; both hold until the next address byte.
- ACK after ADDR:
  - On match, sda_oe=1 for the 9th clock.
  - On mismatch, sda_oe=0 and the block goes to IDLE at the SCL fall, ignoring the bus until START.
- ACK after CMD or a write DATA byte: sda_oe=1 (always ACK).
- ACK after a read DATA byte: sda_oe=0 and the master's bit is sampled on the 9th SCL rise.
  - Master NACK (1): go to IDLE at the next SCL fall and wait for STOP.
  - Master ACK (0): continue.
- TIP:
  - Entered at the SCL fall ending the 9th clock; pre_sm_state is unchanged.
  - Next phase: after ADDR, write → CMD, read → DATA (transmit). After CMD or DATA → DATA.
  - TIP lasts until that phase is taken. For a write, the phase is taken at the next SCL rise. For a read, it is taken within one clock, after the shift register loads.
- Read transmit:
  - On entry to TIP, the shift register loads rd_lock_data. The memory map updates rd_lock_data during ACK, so the value is stable by then.
  - sda_oe is the inverse of each bit, MSB first, and changes only one clock after a filtered SCL fall.
  - sda_oe=0 at the 8th-bit SCL fall.
- sm_state/pre_sm_state are registered and level-held for the whole phase. They never glitch through other values on a transition.
- Timeout:
  - A counter increments while bus_busy && filtered SCL==0, and clears when SCL is high.
  - When it reaches TIMEOUT_CYCLES: go to IDLE, bus_busy=0, sda_oe=0, timeout_err pulses for 1 cycle.
- Reset:
  - sm_state=0, pre_sm_state=0, addr_in=0, data_out=8'h00, r_w=0, sda_oe=0, bus_busy=0, timeout_err=0.
  - Filters preset to 1 (bus idle high).
  - Reset mid-transfer releases SDA on the next clock; no ACK completes.
- Simultaneous START detection and timeout: START wins; counter clears.

Test Plan:
- Write: correct_address=7'h20; master sends START, 0x40, 0x02, 0x05, STOP.
  - Three ACKs with sda_oe=1 on each 9th clock.
  - data_out sequence 0x40 → 0x02 → 0x05.
  - ACK cycles with pre_sm_state 2, 4, 3; TIP after the last byte with pre_sm_state=3.
- Read: START, 0x41; rd_lock_data=8'hFC during ACK.
  - SDA bits shifted out are 1,1,1,1,1,1,0,0 (sda_oe=1 only on the last two).
  - Master NACK → IDLE; STOP → bus_busy=0.
- Mismatch: address byte 0x42 with correct_address=7'h20.
  - No ACK (sda_oe stays 0); sm_state=0 until the next START.
  - addr_in=7'h21.
- Repeated START after the CMD byte 0x06, then 0x41.
  - Enters ADDR without STOP; r_w=1; ACK issued; TIP then DATA in transmit.
- Timeout (TIMEOUT_CYCLES=100 in bench): hold SCL low for 100 cycles mid-DATA.
  - timeout_err pulses once; sm_state=0; sda_oe=0.
- Glitches and reset:
  - A 2-cycle SDA low pulse while SCL is high causes no START.
  - Asserting rst_sync_clk during an ACK releases SDA and gives all-zero outputs one cycle later.
